// File: rtl/i2c_codec_cfg_master.sv
// Write-only I2C master for audio codec configuration: one Avalon DATA write
// sends device address+W, payload[15:8] and payload[7:0], then a STOP.
module i2c_codec_cfg_master #(
  parameter int         CLK_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  q_r, q_s;
  logic [15:0] div_r, div_s;
  logic [1:0]  byte_idx_r, byte_idx_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic        scl_oe_r, scl_oe_s;
  logic        sda_oe_r, sda_oe_s;
  logic [15:0] payload_r;
  logic        busy_r, done_r, nack_r, irq_en_r;
  logic [31:0] readdata_r;
  logic        tick_s, done_set_s, nack_set_s;
  logic        data_wr_s, ctrl_wr_s, start_s;
  logic [7:0]  cur_byte_s;
  logic        unused_s;

  assign data_wr_s = chipselect & ~write_n & (address == 2'd0);
  assign ctrl_wr_s = chipselect & ~write_n & (address == 2'd1);
  assign start_s   = data_wr_s & ~busy_r;
  assign unused_s  = ^writedata[31:16];

  assign tick_s = (state_r != ST_IDLE) && (div_r == DIV_LAST);

  // Byte currently being shifted onto the bus
  always_comb begin
    cur_byte_s = 8'h00;
    case (byte_idx_r)
      2'd0:    cur_byte_s = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte_s = payload_r[15:8];
      2'd2:    cur_byte_s = payload_r[7:0];
      default: cur_byte_s = 8'h00;
    endcase
  end

  // Next-state and pad logic; every pad change is gated by the quarter tick
  always_comb begin
    state_s    = state_r;
    q_s        = q_r;
    div_s      = div_r;
    byte_idx_s = byte_idx_r;
    bit_idx_s  = bit_idx_r;
    scl_oe_s   = scl_oe_r;
    sda_oe_s   = sda_oe_r;
    done_set_s = 1'b0;
    nack_set_s = 1'b0;

    if (state_r == ST_IDLE) begin
      div_s = 16'd0;
    end else if (tick_s) begin
      div_s = 16'd0;
      q_s   = q_r + 2'd1;
    end else begin
      div_s = div_r + 16'd1;
    end

    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s  = ST_START;
          q_s      = 2'd0;
          scl_oe_s = 1'b0;
          sda_oe_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          case (q_r)
            2'd0: begin
              sda_oe_s = 1'b0;
              scl_oe_s = 1'b0;
            end
            2'd1:    sda_oe_s = 1'b1;
            2'd2:    scl_oe_s = 1'b1;
            2'd3: begin
              state_s    = ST_BIT;
              byte_idx_s = 2'd0;
              bit_idx_s  = 3'd7;
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_START;
        end
      end
      ST_BIT: begin
        if (tick_s) begin
          case (q_r)
            2'd0:    sda_oe_s = ~cur_byte_s[bit_idx_r];
            2'd1:    scl_oe_s = 1'b0;
            2'd2:    scl_oe_s = 1'b0;
            2'd3: begin
              scl_oe_s = 1'b1;
              if (bit_idx_r == 3'd0) begin
                state_s = ST_ACK;
              end else begin
                bit_idx_s = bit_idx_r - 3'd1;
              end
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_BIT;
        end
      end
      ST_ACK: begin
        if (tick_s) begin
          case (q_r)
            2'd0:    sda_oe_s = 1'b0;
            2'd1:    scl_oe_s = 1'b0;
            2'd2:    nack_set_s = sda_in;
            2'd3: begin
              // nack_r was loaded by the q2 sample, so the decision sees it here
              scl_oe_s = 1'b1;
              if (nack_r || (byte_idx_r == 2'd2)) begin
                state_s = ST_STOP;
              end else begin
                state_s    = ST_BIT;
                byte_idx_s = byte_idx_r + 2'd1;
                bit_idx_s  = 3'd7;
              end
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_ACK;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          case (q_r)
            2'd0:    sda_oe_s = 1'b1;
            2'd1:    scl_oe_s = 1'b0;
            2'd2:    sda_oe_s = 1'b0;
            2'd3: begin
              state_s    = ST_IDLE;
              done_set_s = 1'b1;
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        scl_oe_s = 1'b0;
        sda_oe_s = 1'b0;
      end
    endcase
  end

  // FSM, divider and pad-drive registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      q_r        <= 2'd0;
      div_r      <= 16'd0;
      byte_idx_r <= 2'd0;
      bit_idx_r  <= 3'd7;
      scl_oe_r   <= 1'b0;
      sda_oe_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      q_r        <= q_s;
      div_r      <= div_s;
      byte_idx_r <= byte_idx_s;
      bit_idx_r  <= bit_idx_s;
      scl_oe_r   <= scl_oe_s;
      sda_oe_r   <= sda_oe_s;
    end
  end

  // Control/status registers; FSM completion beats a CTRL done-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      payload_r <= 16'h0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      nack_r    <= 1'b0;
      irq_en_r  <= 1'b0;
    end else begin
      if (start_s) begin
        payload_r <= writedata[15:0];
        busy_r    <= 1'b1;
      end else if (done_set_s) begin
        busy_r <= 1'b0;
      end

      if (done_set_s) begin
        done_r <= 1'b1;
      end else if (start_s || (ctrl_wr_s && writedata[2])) begin
        done_r <= 1'b0;
      end

      if (start_s) begin
        nack_r <= 1'b0;
      end else if (nack_set_s) begin
        nack_r <= 1'b1;
      end

      if (ctrl_wr_s) begin
        irq_en_r <= writedata[0];
      end
    end
  end

  // Registered read mux
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'd0;
    end else begin
      case (address)
        2'd0:    readdata_r <= {16'h0000, payload_r};
        2'd1:    readdata_r <= {29'd0, done_r, nack_r, busy_r};
        2'd2:    readdata_r <= {31'd0, irq_en_r};
        default: readdata_r <= 32'd0;
      endcase
    end
  end

  assign readdata = readdata_r;
  assign irq      = done_r & irq_en_r;
  assign scl_oe   = scl_oe_r;
  assign sda_oe   = sda_oe_r;

endmodule
